// File: rtl/mmio_pkg.sv
// Register offsets and bit positions for the memory-mapped output port.
package mmio_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_EXIT   = 2'd3;

  localparam int ST_COUNT_W = 3;
  localparam int ST_EMPTY   = 3;
  localparam int ST_FULL    = 4;
  localparam int ST_OVF     = 5;
  localparam int ST_DONE    = 6;

  localparam int CTRL_FLUSH  = 0;
  localparam int CTRL_CLROVF = 1;

endpackage

// File: rtl/mmio_out_port_if.sv
// CPU data-bus side plus outbound stream of the MMIO output port.
interface mmio_out_port_if #(
  parameter int N = 16,
  parameter int A = 16
);
  logic         memwrite;
  logic [A-1:0] dataadr;
  logic [N-1:0] writedata;
  logic         hit;
  logic [N-1:0] readdata;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_ready;
  logic         done;
  logic [N-1:0] done_code;

  modport master (
    output memwrite, dataadr, writedata, out_ready,
    input  hit, readdata, out_valid, out_data, done, done_code
  );

  modport slave (
    input  memwrite, dataadr, writedata, out_ready,
    output hit, readdata, out_valid, out_data, done, done_code
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with separate occupancy counter and flush; 1-cycle write-to-read latency.
// Push when full is accepted only with a concurrent pop; pop when empty is ignored.
module sync_fifo #(
  parameter int N     = 16,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [N-1:0]  din,
  output logic [N-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [N-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Gating on empty makes out_data read 0 the instant reset clears count.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_out_port.sv
// MMIO output peripheral: TXDATA FIFO, STATUS, CTRL and sticky EXIT registers in a 4-word window.
// Stored data appears on out_data one cycle after the store; held stable while out_ready is low.
module mmio_out_port
  import mmio_pkg::*;
#(
  parameter int           N     = 16,
  parameter int           A     = 16,
  parameter logic [A-1:0] BASE  = A'(16'hFF00),
  parameter int           DEPTH = 4,
  localparam int          CW    = $clog2(DEPTH) + 1
) (
  input logic             clk,
  input logic             reset,
  mmio_out_port_if.slave  bus
);

  logic [1:0]    offset;
  logic          wr_hit, push, pop, flush, clr_ovf, exit_wr;
  logic          fifo_full, fifo_empty, overflow, done_q;
  logic [CW-1:0] fifo_count;
  logic [N-1:0]  done_code_q, status;

  assign offset  = bus.dataadr[1:0];
  assign bus.hit = (bus.dataadr[A-1:2] == BASE[A-1:2]);
  assign wr_hit  = bus.memwrite & bus.hit;
  assign push    = wr_hit && (offset == OFF_TXDATA);
  assign exit_wr = wr_hit && (offset == OFF_EXIT);
  assign flush   = wr_hit && (offset == OFF_CTRL) && bus.writedata[CTRL_FLUSH];
  assign clr_ovf = wr_hit && (offset == OFF_CTRL) && bus.writedata[CTRL_CLROVF];
  assign pop     = bus.out_ready & ~fifo_empty;

  sync_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (bus.writedata),
    .dout  (bus.out_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_valid = ~fifo_empty;
  assign bus.done      = done_q;
  assign bus.done_code = done_code_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  // Only the first EXIT store is recorded; the code is the program's final verdict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q      <= 1'b0;
      done_code_q <= '0;
    end else if (exit_wr && !done_q) begin
      done_q      <= 1'b1;
      done_code_q <= bus.writedata;
    end
  end

  always_comb begin
    status                   = '0;
    status[ST_COUNT_W-1:0]   = ST_COUNT_W'(fifo_count);
    status[ST_EMPTY]         = fifo_empty;
    status[ST_FULL]          = fifo_full;
    status[ST_OVF]           = overflow;
    status[ST_DONE]          = done_q;
  end

  assign bus.readdata = (bus.hit && (offset == OFF_STATUS)) ? status : '0;

endmodule

// File: doc/mmio_out_port.md
Name: mmio_out_port

Overview:
Memory-mapped output peripheral that sits beside data memory on the single-cycle CPU's store bus (memwrite / dataadr / writedata).
- Responds to CPU stores and loads inside a 4-word address window.
- Buffers stored bytes/words in a small FIFO and drains them to an external consumer over a valid/ready handshake.
- Provides a sticky "program done" register.
- The top level uses `hit` to steer the readdata mux and to suppress the dmem write.

Parameters:
- N, 16, data width of writedata/readdata/out_data.
- A, 16, address width of dataadr.
- BASE, 16'hFF00, window base address; BASE[1:0] must be 0.
- DEPTH, 4, FIFO depth in entries (power of two, at least 2).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low; clears all state.
- memwrite  input  1  CPU store strobe, same cycle as address and data.
- dataadr  input  A  CPU data address.
- writedata  input  N  CPU store data.
- hit  output  1  combinational; 1 when dataadr[A-1:2] == BASE[A-1:2].
- readdata  output  N  combinational load data for the selected register; 0 when hit=0.
- out_valid  output  1  FIFO non-empty.
- out_data  output  N  FIFO head entry.
- out_ready  input  1  consumer accepts the head entry when out_valid=1.
- done  output  1  sticky; set by a store to EXIT.
- done_code  output  N  value latched by the first store to EXIT.

Behaviour:
- Register map, offset = dataadr[1:0]:
  - 0 TXDATA: store pushes writedata; load returns 0.
  - 1 STATUS: read-only; stores are ignored.
  - 2 CTRL: write-only; bit0 flushes the FIFO, bit1 clears overflow; load returns 0.
  - 3 EXIT: store sets done.
- STATUS layout: [2:0] count (0..DEPTH), [3] empty, [4] full, [5] overflow, [6] done, others 0.
- Reset (reset=0, asynchronous):
  - count=0; read and write pointers 0; overflow=0; done=0; done_code=0.
  - Therefore out_valid=0 and out_data=0.
  - Reset mid-drain discards all entries immediately, without waiting for a clock edge.
- Push: memwrite & hit & offset 0.
  - Entry is written at the posedge.
  - Visible on out_valid/out_data in the following cycle (1-cycle latency).
- Pop: out_valid & out_ready at posedge.
  - Head advances.
  - out_data must stay stable while out_valid=1 and out_ready=0.
- Full:
  - Push with no concurrent pop: data dropped, overflow set (sticky), count unchanged.
  - Push and pop in the same cycle while full: both accepted, count stays DEPTH, no overflow.
- Empty:
  - out_valid=0.
  - out_ready is ignored.
  - Simultaneous push while empty: count becomes 1; out_valid rises next cycle.
- Pointers wrap modulo DEPTH. count is a separate register of width clog2(DEPTH)+1.
- CTRL flush (bit0=1): pointers and count go to 0 at the posedge. A same-cycle pop is discarded (flush wins).
- CTRL bit1=1: overflow cleared. Bit0 and bit1 may both be set in one store.
- EXIT:
  - First store sets done=1 and done_code=writedata.
  - Later EXIT stores are ignored: done_code holds its first value.
  - done clears only on reset.
- Stores and loads with hit=0 have no effect; readdata=0.
- No combinational path from out_ready to hit or readdata.

Decomposition:
- Package `mmio_pkg`:
  - Offset constants: OFF_TXDATA=2'd0, OFF_STATUS=2'd1, OFF_CTRL=2'd2, OFF_EXIT=2'd3.
  - STATUS bit-position constants.
  - CTRL bit constants: CTRL_FLUSH=0, CTRL_CLROVF=1.
- One sub-module `sync_fifo`:
  - Parameters N and DEPTH.
  - Ports: push, pop, flush, din, dout, count, full, empty.
  - Same clk and active-low asynchronous reset.
- mmio_out_port holds the address decode, overflow/done registers and the readdata mux.

Test Plan:
1. Reset: hold reset=0 for 2 cycles, then release → out_valid=0, done=0, done_code=0; a load of BASE+1 returns 0x0008 (empty=1, count=0).
2. Push and drain: store 0x0011, 0x0022, 0x0033 to BASE with out_ready=0 → STATUS=0x0003. Then raise out_ready → out_data sequence 0x0011, 0x0022, 0x0033 on consecutive cycles, then out_valid=0.
3. Overflow: with out_ready=0, store 5 values to BASE → STATUS=0x0034 (count 4, full, overflow) and the 5th value is never output.
   - Store 0x0002 to BASE+2 → overflow bit clears.
   - Store 0x0001 to BASE+2 → STATUS=0x0008.
4. Full with simultaneous pop: fill 4 entries; in one cycle store 0x00AA with out_ready=1 → count stays 4, overflow=0, 0x00AA emerges last.
5. Exit: store 0x0096 to BASE+3, then store 0x0055 to BASE+3 → done=1 and done_code stays 0x0096. A store of 0x0096 to address 84 leaves hit=0 and no state change.
6. Reset mid-operation: with 3 entries queued and out_ready toggling, pull reset=0 between clock edges → out_valid drops immediately; after release STATUS=0x0008.
